// File: rtl/vec_pkg.sv
// Shared types and helpers for the stream-to-vector deserializer.
package vec_pkg;

  // Occupancy of the two-bank ping-pong store, indexed by number of full banks.
  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    ONE_FULL  = 2'd1,
    BOTH_FULL = 2'd2
  } hs_state_e;

  function automatic int clog2p1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n + 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/vec_deser_bank.sv
// One vector bank: indexed element writes, zero padding on first element,
// and a full flag with element count that is set on close and cleared on drain.
module vec_deser_bank #(
  parameter int bit_width = 16,
  parameter int length    = 32,
  parameter int cnt_width = 6,
  parameter int idx_width = 5
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_we,
  input  logic [idx_width-1:0]        i_idx,
  input  logic signed [bit_width-1:0] i_data,
  input  logic                        i_close,
  input  logic                        i_drain,
  output logic signed [bit_width-1:0] o_vec [length],
  output logic [cnt_width-1:0]        o_count,
  output logic                        o_full
);

  logic signed [bit_width-1:0] vec_q [length];
  logic signed [bit_width-1:0] vec_d [length];
  logic [cnt_width-1:0]        count_q, count_d;
  logic                        full_q, full_d;

  always_comb begin
    vec_d   = vec_q;
    count_d = count_q;
    full_d  = full_q;
    if (i_drain) full_d = 1'b0;
    if (i_we) begin
      // The first element of a vector wipes the rest so short vectors read zero-padded.
      for (int k = 0; k < length; k++) begin
        if (k == int'(i_idx)) vec_d[k] = i_data;
        else if (i_idx == '0) vec_d[k] = '0;
      end
      if (i_close) begin
        full_d  = 1'b1;
        count_d = cnt_width'(i_idx) + cnt_width'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < length; k++) vec_q[k] <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      vec_q   <= vec_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign o_vec   = vec_q;
  assign o_count = count_q;
  assign o_full  = full_q;

endmodule

// File: rtl/vec_deser_int.sv
// Ping-pong stream-to-vector deserializer: fills one bank while the other is
// presented, so the input sustains one element per cycle.
module vec_deser_int
  import vec_pkg::*;
#(
  parameter int bit_width = 16,
  parameter int length    = 32,
  parameter int cnt_width = clog2p1(length)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic signed [bit_width-1:0] i_data,
  input  logic                        i_valid,
  input  logic                        i_last,
  output logic                        o_ready,
  output logic signed [bit_width-1:0] o_vec [length],
  output logic [cnt_width-1:0]        o_count,
  output logic                        o_valid,
  input  logic                        i_ready
);

  localparam int idx_width = $clog2(length);

  logic                        wr_ptr_q, wr_ptr_d;
  logic                        rd_ptr_q, rd_ptr_d;
  logic [idx_width-1:0]        idx_q, idx_d;
  logic                        accept, close, drain;
  logic                        full0, full1;
  logic [1:0]                  full;
  logic signed [bit_width-1:0] vec0 [length];
  logic signed [bit_width-1:0] vec1 [length];
  logic [cnt_width-1:0]        count0, count1;

  assign full    = {full1, full0};
  assign o_ready = !full[wr_ptr_q];
  assign o_valid = full[rd_ptr_q];
  assign accept  = i_valid && o_ready;
  // length is a power of two, so the last position is all ones.
  assign close   = (&idx_q) || i_last;
  assign drain   = o_valid && i_ready;

  vec_deser_bank #(
    .bit_width(bit_width), .length(length), .cnt_width(cnt_width), .idx_width(idx_width)
  ) u_bank0 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (accept && !wr_ptr_q),
    .i_idx   (idx_q),
    .i_data  (i_data),
    .i_close (close),
    .i_drain (drain && !rd_ptr_q),
    .o_vec   (vec0),
    .o_count (count0),
    .o_full  (full0)
  );

  vec_deser_bank #(
    .bit_width(bit_width), .length(length), .cnt_width(cnt_width), .idx_width(idx_width)
  ) u_bank1 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (accept && wr_ptr_q),
    .i_idx   (idx_q),
    .i_data  (i_data),
    .i_close (close),
    .i_drain (drain && rd_ptr_q),
    .o_vec   (vec1),
    .o_count (count1),
    .o_full  (full1)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    idx_d    = idx_q;
    if (accept) begin
      if (close) begin
        idx_d    = '0;
        wr_ptr_d = !wr_ptr_q;
      end else begin
        idx_d = idx_q + idx_width'(1);
      end
    end
    if (drain) rd_ptr_d = !rd_ptr_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    for (int k = 0; k < length; k++) o_vec[k] = rd_ptr_q ? vec1[k] : vec0[k];
  end

  assign o_count = o_valid ? (rd_ptr_q ? count1 : count0) : '0;

endmodule
